// File: rtl/inst_pkg.sv
// Shared field layout and stored-entry type for the instruction fetch queue.
package inst_pkg;

    localparam int unsigned INST_BITS = 16;

    localparam int unsigned OPC_HI = 15;
    localparam int unsigned OPC_LO = 12;
    localparam int unsigned RD_HI  = 11;
    localparam int unsigned RD_LO  = 8;
    localparam int unsigned EXT_HI = 7;
    localparam int unsigned EXT_LO = 4;
    localparam int unsigned RS_HI  = 3;
    localparam int unsigned RS_LO  = 0;
    localparam int unsigned IMM_HI = 7;
    localparam int unsigned IMM_LO = 0;

    typedef struct packed {
        logic [INST_BITS-1:0] inst;
        logic                 s;
        logic                 sext;
    } entry_t;

endpackage

// File: rtl/inst_field_decode.sv
// Splits a queued instruction into its fields; everything reads zero when the entry is not valid.
module inst_field_decode
    import inst_pkg::*;
#(
    parameter int unsigned INST_W = 16,
    parameter int unsigned REG_W  = 4,
    parameter int unsigned IMM_W  = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic [INST_W-1:0] inst,
    input  logic              s,
    input  logic              sext,
    input  logic              valid,
    output logic [REG_W-1:0]  op_code,
    output logic [REG_W-1:0]  rdest,
    output logic [REG_W-1:0]  op_ext,
    output logic [REG_W-1:0]  rsrc,
    output logic [IMM_W-1:0]  imm,
    output logic [DATA_W-1:0] imm_ext,
    output logic              is_imm
);

    logic [IMM_W-1:0] w_imm;

    assign w_imm = inst[IMM_HI:IMM_LO];

    always_comb begin
        op_code = '0;
        rdest   = '0;
        op_ext  = '0;
        rsrc    = '0;
        imm     = '0;
        imm_ext = '0;
        is_imm  = 1'b0;
        if (valid) begin
            op_code = inst[OPC_HI:OPC_LO];
            rdest   = inst[RD_HI:RD_LO];
            is_imm  = s;
            if (s) begin
                imm     = w_imm;
                // Signed cast replicates the immediate's top bit into the upper bits.
                imm_ext = sext ? DATA_W'($signed(w_imm)) : DATA_W'(w_imm);
            end else begin
                op_ext = inst[EXT_HI:EXT_LO];
                rsrc   = inst[RS_HI:RS_LO];
            end
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction buffer between fetch and decode: DEPTH-entry FIFO with flush and field split of the head.
module inst_fetch_queue
    import inst_pkg::*;
#(
    parameter int unsigned INST_W = 16,
    parameter int unsigned REG_W  = 4,
    parameter int unsigned IMM_W  = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INST_W-1:0]          in_inst,
    input  logic                       in_s,
    input  logic                       in_sext,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [REG_W-1:0]           op_code,
    output logic [REG_W-1:0]           rdest,
    output logic [REG_W-1:0]           op_ext,
    output logic [REG_W-1:0]           rsrc,
    output logic [IMM_W-1:0]           imm,
    output logic [DATA_W-1:0]          imm_ext,
    output logic                       is_imm,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_live;
    entry_t           r_mem [DEPTH];
    entry_t           w_head;
    logic             w_push;
    logic             w_pop;

    // r_live holds in_ready low until the first edge after reset release.
    assign in_ready  = r_live && (r_count < CNT_W'(DEPTH)) && !flush;
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready && !flush;
    assign count     = r_count;
    assign w_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_live   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    // Storage is never reset; stale entries are hidden by out_valid masking.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{inst: INST_BITS'(in_inst), s: in_s, sext: in_sext};
        end
    end

    inst_field_decode #(
        .INST_W (INST_BITS),
        .REG_W  (REG_W),
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) u_decode (
        .inst    (w_head.inst),
        .s       (w_head.s),
        .sext    (w_head.sext),
        .valid   (out_valid),
        .op_code (op_code),
        .rdest   (rdest),
        .op_ext  (op_ext),
        .rsrc    (rsrc),
        .imm     (imm),
        .imm_ext (imm_ext),
        .is_imm  (is_imm)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised scoreboard bench for inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_inst = '0;
    logic        in_s = 1'b0;
    logic        in_sext = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  op_code, rdest, op_ext, rsrc;
    logic [7:0]  imm;
    logic [15:0] imm_ext;
    logic        is_imm;
    logic [2:0]  count;

    inst_fetch_queue #(.INST_W(16), .REG_W(4), .IMM_W(8), .DATA_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_s(in_s), .in_sext(in_sext),
        .out_valid(out_valid), .out_ready(out_ready),
        .op_code(op_code), .rdest(rdest), .op_ext(op_ext), .rsrc(rsrc),
        .imm(imm), .imm_ext(imm_ext), .is_imm(is_imm), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int op, rd, ext, rs, im, imx, isimm;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   live = 1'b0;
    bit   exp_ready = 1'b0;
    bit   mon_en = 1'b0;

    function automatic exp_t model(input int inst, input bit s, input bit sx);
        exp_t e;
        e.op    = inst / 4096;
        e.rd    = (inst / 256) % 16;
        e.isimm = s;
        if (s) begin
            e.im  = inst % 256;
            e.imx = (sx && e.im >= 128) ? e.im + 65280 : e.im;
            e.ext = 0;
            e.rs  = 0;
        end else begin
            e.im  = 0;
            e.imx = 0;
            e.ext = (inst / 16) % 16;
            e.rs  = inst % 16;
        end
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare DUT against the model head, then retire it on a consumed pop.
    always @(negedge clk) begin
        if (mon_en) begin
            check("count", int'(count), q.size());
            check("out_valid", int'(out_valid), int'(q.size() != 0));
            check("in_ready", int'(in_ready), int'(exp_ready));
            if (q.size() != 0) begin
                check("op_code", int'(op_code), q[0].op);
                check("rdest", int'(rdest), q[0].rd);
                check("op_ext", int'(op_ext), q[0].ext);
                check("rsrc", int'(rsrc), q[0].rs);
                check("imm", int'(imm), q[0].im);
                check("imm_ext", int'(imm_ext), q[0].imx);
                check("is_imm", int'(is_imm), q[0].isimm);
                if (out_ready && !flush) void'(q.pop_front());
            end else begin
                check("fields_zero", int'({op_code, rdest, op_ext, rsrc, imm, is_imm}), 0);
                check("imm_ext_zero", int'(imm_ext), 0);
            end
        end
    end

    // One clock of stimulus; the model's push/flush side is applied at the edge.
    task automatic step(input bit v, input int inst, input bit s, input bit sx,
                        input bit ordy, input bit fl);
        in_valid  = v;
        in_inst   = 16'(inst);
        in_s      = s;
        in_sext   = sx;
        out_ready = ordy;
        flush     = fl;
        exp_ready = live && (q.size() < DEPTH) && !fl;
        @(posedge clk);
        if (fl) q.delete();
        else if (v && exp_ready) q.push_back(model(inst, s, sx));
        live = rst_n;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_count", int'(count), 0);
        check("rst_imm_ext", int'(imm_ext), 0);
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0);

        // Immediate form, zero-extended.
        step(1, 16'h5A3C, 1, 0, 0, 0);
        check("t1_op_code", int'(op_code), 5);
        check("t1_rdest", int'(rdest), 10);
        check("t1_imm_ext", int'(imm_ext), 16'h003C);
        check("t1_is_imm", int'(is_imm), 1);
        step(0, 0, 0, 0, 1, 0);

        // Register form.
        step(1, 16'h5A3C, 0, 0, 0, 0);
        check("t2_op_ext", int'(op_ext), 3);
        check("t2_rsrc", int'(rsrc), 12);
        check("t2_imm", int'(imm), 0);
        step(0, 0, 0, 0, 1, 0);

        // Sign- vs zero-extension of a negative immediate.
        step(1, 16'h1280, 1, 1, 0, 0);
        step(1, 16'h1280, 1, 0, 0, 0);
        check("t3_sext", int'(imm_ext), 16'hFF80);
        step(0, 0, 0, 0, 1, 0);
        check("t3_zext", int'(imm_ext), 16'h0080);
        step(0, 0, 0, 0, 1, 0);

        // Fill, blocked 5th push, pop-while-full does not admit it.
        for (int i = 0; i < 4; i++) step(1, 16'h1000 + i, 0, 0, 0, 0);
        check("full_count", int'(count), 4);
        check("full_in_ready", int'(in_ready), 0);
        step(1, 16'hABCD, 0, 0, 0, 0);
        step(1, 16'hABCD, 0, 0, 1, 0);
        check("pop_full_count", int'(count), 3);
        step(1, 16'hABCD, 0, 0, 1, 0);
        check("after_pop_count", int'(count), 3);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);

        // Flush with concurrent push and pop.
        for (int i = 0; i < 3; i++) step(1, 16'h2200 + i, 1, 1, 0, 0);
        step(1, 16'h7777, 0, 0, 1, 1);
        check("flush_count", int'(count), 0);
        check("flush_out_valid", int'(out_valid), 0);
        step(0, 0, 0, 0, 0, 0);

        // Continuous stream wraps the pointers; then an asynchronous reset mid-stream.
        for (int i = 0; i < 10; i++) step(1, int'($urandom_range(0, 65535)), i[0], i[1], 1, 0);
        check("stream_count", int'(count), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_count", int'(count), 0);
        check("arst_in_ready", int'(in_ready), 0);
        q.delete();
        live = 1'b0;
        exp_ready = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 65535)),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 15) == 0));
        end
        step(0, 0, 0, 0, 0, 0);
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
